// File: rtl/edge_frame_ctrl.sv
// edge_frame_ctrl: frame sequencer for the edge-detection datapath; EDGE_CTRL_PERF_EN adds cycle_cnt
module edge_frame_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ADDR_W = 12,
  parameter int OUT_TOTAL = 3844,
  parameter int DRAIN_MAX = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [19:0]       cfg_threshold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              det_rst,
  output logic [19:0]       threshold,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  input  logic              det_en,
  input  logic [7:0]        det_x,
  input  logic [7:0]        det_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
`ifdef EDGE_CTRL_PERF_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);
  localparam int DW = $clog2(DRAIN_MAX) + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_OUT = ADDR_W'(OUT_TOTAL - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_MAX - 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] rd_cnt, out_cnt;
  logic [DW-1:0] drain_cnt;
  logic rd_vld, go, complete, timeout, capture;
  assign go = state == IDLE && start;
  assign busy = state == FEED || state == DRAIN;
  assign done = state == DONE;
  assign det_rst = busy;
  assign rd_en = state == FEED;
  assign rd_addr = rd_cnt;
  // the last result write is in flight this cycle; further det_en is surplus
  assign complete = wr_en && wr_addr == LAST_OUT;
  assign timeout = state == DRAIN && drain_cnt == LAST_DRAIN;
  assign capture = busy && det_en && !complete;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (go) state_nx = FEED;
    else if (busy && (complete || timeout)) state_nx = DONE;
    else if (state == FEED && rd_cnt == LAST_PIX) state_nx = DRAIN;
    else if (done) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_cnt <= '0;
      out_cnt <= '0;
      drain_cnt <= '0;
      err <= 1'b0;
      rd_vld <= 1'b0;
      {R, G, B} <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      threshold <= '0;
    end else begin
      rd_vld <= rd_en;
      {R, G, B} <= rd_vld ? rd_data : '0;
      wr_en <= capture;
      if (capture) begin
        wr_addr <= out_cnt;
        wr_data <= {det_x, det_y};
        out_cnt <= out_cnt + 1'b1;
      end
      if (state == IDLE && cfg_we && !start) threshold <= cfg_threshold;
      if (go) begin
        rd_cnt <= '0;
        out_cnt <= '0;
        drain_cnt <= '0;
        err <= 1'b0;
      end else begin
        if (rd_en && rd_cnt != LAST_PIX) rd_cnt <= rd_cnt + 1'b1;
        if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
        if (timeout && !complete) err <= 1'b1;
      end
    end
`ifdef EDGE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) cycle_cnt <= '0;
    else if (go) cycle_cnt <= '0;
    else if (busy) cycle_cnt <= cycle_cnt + 1;
`endif
endmodule

// File: doc/edge_frame_ctrl.md
Name: edge_frame_ctrl

Overview:
- Frame-level sequencer for the Edge_Detection datapath (Intensity -> LineBuffer -> Conv).
- Streams one RGB frame from a synchronous-read input memory into the datapath and clears the line buffer between frames.
- Owns the detection threshold register.
- Captures each valid out_x/out_y result into an output memory, then signals frame completion with start/busy/done handshake.

Parameters:
IMG_W, 64, frame width in pixels.
IMG_H, 64, frame height in pixels.
ADDR_W, 12, address width of both memories; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
OUT_TOTAL, 3844, number of det_en-qualified results per frame ((IMG_W-2)*(IMG_H-2)).
DRAIN_MAX, 256, maximum flush cycles after the last input pixel before aborting.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle frame request; honoured only in IDLE.
cfg_we  in  1  threshold write strobe; honoured only in IDLE.
cfg_threshold  in  20  signed threshold value.
busy  out  1  high from FEED through DRAIN.
done  out  1  one-cycle pulse at frame end.
err  out  1  set on drain timeout; cleared by next accepted start.
rd_en  out  1  input memory read enable.
rd_addr  out  ADDR_W  input pixel address, raster order.
rd_data  in  24  {R,G,B}, valid the cycle after rd_en.
det_rst  out  1  active-low reset to datapath line buffer.
threshold  out  20  registered threshold to datapath.
R, G, B  out  8 each  registered pixel to datapath.
det_en  in  1  datapath window-valid.
det_x, det_y  in  8 each  datapath results.
wr_en  out  1  output memory write enable.
wr_addr  out  ADDR_W  output result index.
wr_data  out  16  {det_x, det_y}.

Behaviour:
- Reset values: state IDLE; all outputs 0 except det_rst=0 (datapath held in reset); threshold=0; internal counters 0.
- States:
  - IDLE:
    - det_rst=0; busy=0.
    - cfg_we latches cfg_threshold into threshold the next cycle.
    - start (cfg_we ignored if simultaneous) -> FEED. rd_cnt=0, out_cnt=0, err=0, det_rst=1 from the next cycle.
  - FEED:
    - rd_en=1, rd_addr=rd_cnt, rd_cnt increments each cycle.
    - The cycle after each rd_en, rd_data is registered onto R/G/B, so a pixel reaches the datapath 2 cycles after its address.
    - After address IMG_W*IMG_H-1 is issued -> DRAIN. rd_en drops the same cycle.
  - DRAIN:
    - R/G/B=0 flush pixels (after the final real pixel is delivered).
    - drain_cnt increments each cycle.
    - drain_cnt==DRAIN_MAX-1 without completion -> DONE with err=1.
  - DONE: done=1 for one cycle, det_rst=0 -> IDLE.
- Result capture (FEED or DRAIN):
  - When det_en=1, the next cycle wr_en=1, wr_addr=out_cnt, wr_data={det_x,det_y}, and out_cnt increments.
  - When the write of index OUT_TOTAL-1 is issued, move to DONE the following cycle. This can occur during FEED; remaining reads are then abandoned.
  - det_en outside FEED/DRAIN is ignored.
- Boundaries:
  - start while busy is ignored.
  - Counter wrap never occurs; rd_cnt stops at IMG_W*IMG_H-1.
  - Completion and timeout in the same cycle: completion wins, err=0.
- Reset assertion mid-frame aborts immediately to reset values. No done is issued.

Optional Feature:
EDGE_CTRL_PERF_EN:
- Defined: adds output cycle_cnt [31:0].
  - Cleared on accepted start, increments every cycle while busy, holds its value after DONE.
  - Holds FEED+DRAIN duration.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- IMG_W=4, IMG_H=4, OUT_TOTAL=4: cfg_we with threshold=100, then start -> threshold=100, rd_addr 0..15 on consecutive cycles, busy=1 from the cycle after start.
- Same config, stub det_en high for 4 cycles in DRAIN with det_x=8'hA0+i, det_y=i -> wr_addr 0..3, wr_data {A0,00}..{A3,03}, then done pulse with err=0, busy=0.
- Stub det_en never asserted, DRAIN_MAX=8 -> done 8 cycles into DRAIN, err=1, wr_en never high.
- start and cfg_we asserted while busy -> frame unaffected, threshold unchanged.
- rst pulled low at rd_addr=7 -> next edge all outputs at reset values, det_rst=0, no done. A new start restarts at rd_addr=0.
- With EDGE_CTRL_PERF_EN, nominal 4x4 frame -> cycle_cnt equals cycles from the first busy=1 to the last busy=1 inclusive, stable after done.
